la_sram_writer: RTL and testbench
=================================

Name: la_sram_writer

Overview:
- Capture-memory write controller directly downstream of the RLE compressor.
- Takes each RLE record (sample byte plus run count) qualified by the compressor's address-count enable and writes it into external SRAM as a 16-bit word through a circular address pointer.
- Implements pre-trigger fill, trigger wait, post-trigger countdown and stop, then reports the trigger address to the readout logic.

Parameters:
ADDR_W, 19, SRAM word-address width; buffer depth is 2^ADDR_W words.
CNT_W, 19, width of the PRE_CNT and POST_CNT record counters.

Ports:
CLK  in  1  sample clock, shared with the RLE stage
RST_N  in  1  asynchronous active-low reset
CLK_EN  in  1  sample-rate qualifier, same signal the RLE stage uses; all logic holds state when 0
START  in  1  one-CLK pulse that arms a capture
ABORT  in  1  one-CLK pulse that forces IDLE
RLE_EN  in  1  RLE mode enable; gates the overflow write
LA_DATA  in  8  sample byte from the RLE stage
LA_RLE_CNT  in  8  run count from the RLE stage
LA_SRAM_ADDR_CNT_EN  in  1  record-valid strobe from the RLE stage
TRIG  in  1  trigger-condition strobe, aligned with LA_SRAM_ADDR_CNT_EN
PRE_CNT  in  CNT_W  minimum number of records to write before a trigger is accepted
POST_CNT  in  CNT_W  number of records to write after the trigger record
SRAM_ADDR  out  ADDR_W  SRAM word address
SRAM_DATA  out  16  write word {LA_DATA, LA_RLE_CNT}
SRAM_WE_N  out  1  active-low write strobe
BUSY  out  1  high in the PRE, ARMED and POST states
TRIGGERED  out  1  high from trigger acceptance until the next START
DONE  out  1  high in the DONE state
TRIG_ADDR  out  ADDR_W  SRAM address of the trigger record

Behaviour:
- Reset values:
  - SRAM_ADDR = 0, SRAM_DATA = 0, SRAM_WE_N = 1.
  - BUSY = 0, TRIGGERED = 0, DONE = 0, TRIG_ADDR = 0.
  - State = IDLE; internal pointer and counters = 0.
- Record qualification: rec = CLK_EN & (LA_SRAM_ADDR_CNT_EN | (RLE_EN & LA_RLE_CNT == 8'hFF)).
  - The second term is the overflow write, so runs longer than 255 are stored as consecutive records.
- Write timing. If rec is sampled in PRE, ARMED or POST on edge N:
  - On edge N+1: SRAM_DATA <= {LA_DATA, LA_RLE_CNT}, SRAM_ADDR <= ptr, SRAM_WE_N <= 0, ptr <= ptr + 1.
  - Latency is one CLK.
  - SRAM_WE_N returns to 1 on the first edge where no record qualifies.
  - Back-to-back records keep SRAM_WE_N low while SRAM_ADDR advances by 1 per cycle.
  - SRAM_DATA and SRAM_ADDR hold their values when there is no write.
- Pointer: ADDR_W-bit, wraps from 2^ADDR_W-1 to 0 with no flag; it is a circular buffer.
- When CLK_EN = 0: no writes, SRAM_WE_N = 1 on the next edge, state and counters frozen.
- State machine:
  - IDLE: START -> PRE, with ptr <= 0, pre counter <= 0, TRIGGERED <= 0, DONE <= 0.
  - PRE: each written record increments the pre counter. When the counter reaches PRE_CNT -> ARMED. If PRE_CNT = 0, go to ARMED on the cycle after START. TRIG is ignored in PRE.
  - ARMED: a qualifying record with TRIG = 1 is the trigger record. It is written; TRIG_ADDR <= that record's address; TRIGGERED <= 1; post counter <= POST_CNT. Then -> POST, or -> DONE directly if POST_CNT = 0.
  - POST: each written record decrements the post counter. The record that brings it to 0 is written, then -> DONE. Total records after the trigger record = POST_CNT exactly.
  - DONE: no writes. DONE = 1 and TRIG_ADDR stable until START, which behaves as it does from IDLE.
- ABORT in any state -> IDLE on the next edge:
  - Any write already scheduled for that edge is suppressed; SRAM_WE_N = 1.
  - TRIGGERED and TRIG_ADDR are kept.
  - ABORT has priority over START in the same cycle.
- START while BUSY is ignored.
- TRIG without a qualifying record is ignored.
- PRE_CNT and POST_CNT are sampled once each: PRE_CNT at START, POST_CNT at trigger. Later changes have no effect on a running capture.
- Reset mid-operation: asynchronous return to all reset values; SRAM_WE_N deasserts immediately.

Decomposition:
- Shared package la_pkg:
  - state encoding ST_IDLE, ST_PRE, ST_ARMED, ST_POST, ST_DONE
  - constant RLE_MAX = 8'hFF
  - default ADDR_W and CNT_W
- Sub-module la_wr_ptr: ADDR_W wrapping pointer with increment enable and synchronous clear.
- The FSM, counters and output registers stay in la_sram_writer.

Test Plan:
1. Reset mid-PRE with SRAM_WE_N = 0 -> SRAM_WE_N = 1 immediately, all outputs 0, IDLE; the next START works normally.
2. PRE_CNT = 4, POST_CNT = 3, a record every cycle, TRIG on record 6 -> writes at addresses 0..8, TRIG_ADDR = 5, DONE one cycle after the write to address 8, exactly 9 SRAM_WE_N-low cycles, DONE = 1.
3. TRIG pulsed on record 2 with PRE_CNT = 4 -> trigger ignored, TRIGGERED = 0; the first TRIG on record 5 or later is accepted.
4. ADDR_W = 4, PRE_CNT = 20, trigger on record 21, POST_CNT = 2 -> address sequence wraps 15 -> 0, TRIG_ADDR = 4, final write at address 6.
5. RLE_EN = 1, LA_RLE_CNT reaches 8'hFF without the strobe -> one write of {data, 8'hFF}. With RLE_EN = 0 the same input -> no write.
6. ABORT in POST alongside a qualifying record -> no write that cycle, IDLE, TRIGGERED = 1 retained, DONE = 0. START in the same cycle as ABORT -> stays IDLE.

Source files
------------

// File: rtl/la_pkg.sv
// Shared types and constants for the logic-analyser capture write path.
package la_pkg;

  localparam int unsigned DEF_ADDR_W = 19;
  localparam int unsigned DEF_CNT_W  = 19;

  // Run count at which the RLE stage forces an overflow record.
  localparam logic [7:0] RLE_MAX = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_ARMED,
    ST_POST,
    ST_DONE
  } la_state_e;

endpackage

// File: rtl/la_sram_writer_if.sv
// SRAM write bus between the capture controller and the memory pins.
interface la_sram_writer_if
  import la_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
);

  logic [ADDR_W-1:0] SRAM_ADDR;
  logic [15:0]       SRAM_DATA;
  logic              SRAM_WE_N;

  modport master (
    output SRAM_ADDR,
    output SRAM_DATA,
    output SRAM_WE_N
  );

  modport slave (
    input SRAM_ADDR,
    input SRAM_DATA,
    input SRAM_WE_N
  );

endinterface

// File: rtl/la_wr_ptr.sv
// Circular SRAM word pointer: wraps silently at 2^ADDR_W.
module la_wr_ptr
  import la_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CLR,
  input  logic              INC,
  output logic [ADDR_W-1:0] PTR
);

  logic [ADDR_W-1:0] ptr_q;

  // Clear wins over increment so a new capture always starts at word 0.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr_q <= '0;
    end else if (CLR) begin
      ptr_q <= '0;
    end else if (INC) begin
      ptr_q <= ptr_q + ADDR_W'(1);
    end
  end

  assign PTR = ptr_q;

endmodule

// File: rtl/la_sram_writer.sv
// Capture-memory write controller: stores RLE records into a circular SRAM
// buffer with pre-trigger fill, trigger wait and post-trigger countdown.
module la_sram_writer
  import la_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CLK_EN,
  input  logic              START,
  input  logic              ABORT,
  input  logic              RLE_EN,
  input  logic [7:0]        LA_DATA,
  input  logic [7:0]        LA_RLE_CNT,
  input  logic              LA_SRAM_ADDR_CNT_EN,
  input  logic              TRIG,
  input  logic [CNT_W-1:0]  PRE_CNT,
  input  logic [CNT_W-1:0]  POST_CNT,
  la_sram_writer_if.master  sram,
  output logic              BUSY,
  output logic              TRIGGERED,
  output logic              DONE,
  output logic [ADDR_W-1:0] TRIG_ADDR
);

  la_state_e state_q, state_d;

  logic [ADDR_W-1:0] ptr;
  logic [CNT_W-1:0]  pre_cnt_q;
  logic [CNT_W-1:0]  pre_tgt_q;
  logic [CNT_W-1:0]  post_cnt_q;
  logic [ADDR_W-1:0] sram_addr_q;
  logic [15:0]       sram_data_q;
  logic              sram_we_n_q;
  logic              triggered_q;
  logic [ADDR_W-1:0] trig_addr_q;

  logic rec;
  logic start_acc;
  logic wr_en;
  logic trig_acc;
  logic pre_last;

  // Record qualification and the per-cycle write/trigger/start decisions.
  always_comb begin
    rec       = CLK_EN & (LA_SRAM_ADDR_CNT_EN | (RLE_EN & (LA_RLE_CNT == RLE_MAX)));
    start_acc = CLK_EN & START & ~ABORT & ((state_q == ST_IDLE) | (state_q == ST_DONE));
    // POST stops writing once the countdown is exhausted; DONE follows next edge.
    wr_en     = rec & ~ABORT & ((state_q == ST_PRE) | (state_q == ST_ARMED) |
                               ((state_q == ST_POST) & (post_cnt_q != '0)));
    trig_acc  = wr_en & (state_q == ST_ARMED) & TRIG;
    // Arm on the edge that writes the last pre-trigger record, or at once if
    // the target is already met (PRE_CNT = 0).
    pre_last  = (pre_cnt_q == pre_tgt_q) | (rec & ((pre_cnt_q + CNT_W'(1)) == pre_tgt_q));
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; everything freezes while CLK_EN is low.
  always_comb begin
    state_d = state_q;
    if (CLK_EN) begin
      if (ABORT) begin
        state_d = ST_IDLE;
      end else begin
        unique case (state_q)
          ST_IDLE, ST_DONE: begin
            if (START) state_d = ST_PRE;
          end
          ST_PRE: begin
            if (pre_last) state_d = ST_ARMED;
          end
          ST_ARMED: begin
            if (trig_acc) state_d = (POST_CNT == '0) ? ST_DONE : ST_POST;
          end
          ST_POST: begin
            if (post_cnt_q == '0) state_d = ST_DONE;
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  // Status outputs decoded from the current state.
  always_comb begin
    BUSY = (state_q == ST_PRE) | (state_q == ST_ARMED) | (state_q == ST_POST);
    DONE = (state_q == ST_DONE);
  end

  // Pre-trigger count and the PRE_CNT snapshot taken at START.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pre_cnt_q <= '0;
      pre_tgt_q <= '0;
    end else if (start_acc) begin
      pre_cnt_q <= '0;
      pre_tgt_q <= PRE_CNT;
    end else if (wr_en && (state_q == ST_PRE)) begin
      pre_cnt_q <= pre_cnt_q + CNT_W'(1);
    end
  end

  // Post-trigger countdown, loaded from POST_CNT by the trigger record.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      post_cnt_q <= '0;
    end else if (trig_acc) begin
      post_cnt_q <= POST_CNT;
    end else if (wr_en && (state_q == ST_POST)) begin
      post_cnt_q <= post_cnt_q - CNT_W'(1);
    end
  end

  // Trigger flag and address; both survive ABORT, only START clears the flag.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      triggered_q <= 1'b0;
      trig_addr_q <= '0;
    end else if (start_acc) begin
      triggered_q <= 1'b0;
    end else if (trig_acc) begin
      triggered_q <= 1'b1;
      trig_addr_q <= ptr;
    end
  end

  // SRAM bus registers; address and data hold between writes.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sram_addr_q <= '0;
      sram_data_q <= '0;
      sram_we_n_q <= 1'b1;
    end else begin
      sram_we_n_q <= ~wr_en;
      if (wr_en) begin
        sram_addr_q <= ptr;
        sram_data_q <= {LA_DATA, LA_RLE_CNT};
      end
    end
  end

  la_wr_ptr #(
    .ADDR_W (ADDR_W)
  ) u_wr_ptr (
    .CLK   (CLK),
    .RST_N (RST_N),
    .CLR   (start_acc),
    .INC   (wr_en),
    .PTR   (ptr)
  );

  assign sram.SRAM_ADDR = sram_addr_q;
  assign sram.SRAM_DATA = sram_data_q;
  assign sram.SRAM_WE_N = sram_we_n_q;
  assign TRIGGERED      = triggered_q;
  assign TRIG_ADDR      = trig_addr_q;

endmodule

// File: tb/tb_la_sram_writer.sv
// Scoreboard bench for la_sram_writer with a 16-word buffer.
module tb_la_sram_writer;

  localparam int unsigned AW = 4;
  localparam int unsigned CW = 8;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          CLK_EN;
  logic          START;
  logic          ABORT;
  logic          RLE_EN;
  logic [7:0]    LA_DATA;
  logic [7:0]    LA_RLE_CNT;
  logic          LA_SRAM_ADDR_CNT_EN;
  logic          TRIG;
  logic [CW-1:0] PRE_CNT;
  logic [CW-1:0] POST_CNT;
  logic          BUSY;
  logic          TRIGGERED;
  logic          DONE;
  logic [AW-1:0] TRIG_ADDR;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int wr_base;
  logic [19:0] exp_q[$];
  logic [19:0] exp_w;

  la_sram_writer_if #(.ADDR_W(AW)) sram ();

  la_sram_writer #(
    .ADDR_W (AW),
    .CNT_W  (CW)
  ) dut (
    .CLK                 (CLK),
    .RST_N               (RST_N),
    .CLK_EN              (CLK_EN),
    .START               (START),
    .ABORT               (ABORT),
    .RLE_EN              (RLE_EN),
    .LA_DATA             (LA_DATA),
    .LA_RLE_CNT          (LA_RLE_CNT),
    .LA_SRAM_ADDR_CNT_EN (LA_SRAM_ADDR_CNT_EN),
    .TRIG                (TRIG),
    .PRE_CNT             (PRE_CNT),
    .POST_CNT            (POST_CNT),
    .sram                (sram),
    .BUSY                (BUSY),
    .TRIGGERED           (TRIGGERED),
    .DONE                (DONE),
    .TRIG_ADDR           (TRIG_ADDR)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Every low-WE cycle is one write; it must match the oldest expected write.
  always @(negedge CLK) begin
    if (RST_N === 1'b1 && sram.SRAM_WE_N === 1'b0) begin
      wr_count++;
      check_eq("sb_pending", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp_q.size() > 0) begin
        exp_w = exp_q.pop_front();
        check_eq("sb_write", {12'b0, sram.SRAM_ADDR, sram.SRAM_DATA}, {12'b0, exp_w});
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_cap(input logic [CW-1:0] pre, input logic [CW-1:0] post);
    PRE_CNT  = pre;
    POST_CNT = post;
    START    = 1'b1;
    step();
    START    = 1'b0;
    PRE_CNT  = 8'd200;  // must be ignored once the capture is running
  endtask

  task automatic rec(input logic [7:0] d, input logic t, input bit exp_wr,
                     input logic [AW-1:0] a);
    LA_DATA             = d;
    LA_RLE_CNT          = d ^ 8'h3C;
    LA_SRAM_ADDR_CNT_EN = 1'b1;
    TRIG                = t;
    if (exp_wr) exp_q.push_back({a, d, d ^ 8'h3C});
    step();
    LA_SRAM_ADDR_CNT_EN = 1'b0;
    TRIG                = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0; CLK_EN = 1'b1; START = 1'b0; ABORT = 1'b0; RLE_EN = 1'b0;
    LA_DATA = '0; LA_RLE_CNT = '0; LA_SRAM_ADDR_CNT_EN = 1'b0; TRIG = 1'b0;
    PRE_CNT = '0; POST_CNT = '0;
    repeat (3) step();
    check_eq("rst_we_n", 32'(sram.SRAM_WE_N), 32'd1);
    check_eq("rst_addr", 32'(sram.SRAM_ADDR), 32'd0);
    check_eq("rst_data", 32'(sram.SRAM_DATA), 32'd0);
    check_eq("rst_flags", {29'b0, BUSY, TRIGGERED, DONE}, 32'd0);
    check_eq("rst_trig_addr", 32'(TRIG_ADDR), 32'd0);
    RST_N = 1'b1;
    step();

    // 1: asynchronous reset while a write is on the bus
    start_cap(8'd10, 8'd3);
    check_eq("t1_busy", 32'(BUSY), 32'd1);
    rec(8'h11, 1'b0, 1'b1, 4'd0);
    rec(8'h12, 1'b0, 1'b0, 4'd0);
    check_eq("t1_we_low", 32'(sram.SRAM_WE_N), 32'd0);
    #1 RST_N = 1'b0;
    #1;
    check_eq("t1_we_high", 32'(sram.SRAM_WE_N), 32'd1);
    check_eq("t1_addr", 32'(sram.SRAM_ADDR), 32'd0);
    check_eq("t1_data", 32'(sram.SRAM_DATA), 32'd0);
    check_eq("t1_flags", {29'b0, BUSY, TRIGGERED, DONE}, 32'd0);
    step();
    RST_N = 1'b1;
    step();

    // 2: PRE 4, POST 3, trigger on record 6
    wr_base = wr_count;
    start_cap(8'd4, 8'd3);
    for (int i = 1; i <= 12; i++) begin
      rec(8'(32'h20 + i), (i == 6), (i <= 9), 4'(i - 1));
      if (i == 5) check_eq("t2_not_trig", 32'(TRIGGERED), 32'd0);
      if (i == 6) begin
        check_eq("t2_trig", 32'(TRIGGERED), 32'd1);
        POST_CNT = 8'd50;  // must be ignored after the trigger
      end
      if (i == 9) check_eq("t2_done_late", 32'(DONE), 32'd0);
      if (i == 10) begin
        check_eq("t2_done", 32'(DONE), 32'd1);
        check_eq("t2_idle_busy", 32'(BUSY), 32'd0);
      end
    end
    check_eq("t2_trig_addr", 32'(TRIG_ADDR), 32'd5);
    check_eq("t2_writes", 32'(wr_count - wr_base), 32'd9);

    // 3: early trigger ignored in PRE, record 5 accepted
    start_cap(8'd4, 8'd1);
    check_eq("t3_trig_clr", 32'(TRIGGERED), 32'd0);
    for (int i = 1; i <= 6; i++) begin
      rec(8'(32'h40 + i), (i == 2) || (i == 5), 1'b1, 4'(i - 1));
      if (i == 2) check_eq("t3_ignored", 32'(TRIGGERED), 32'd0);
      if (i == 5) begin
        check_eq("t3_trig", 32'(TRIGGERED), 32'd1);
        check_eq("t3_trig_addr", 32'(TRIG_ADDR), 32'd4);
      end
    end
    step();
    check_eq("t3_done", 32'(DONE), 32'd1);

    // 4: address wrap, trigger on record 21
    start_cap(8'd20, 8'd2);
    for (int i = 1; i <= 23; i++) begin
      rec(8'(32'h80 + i), (i == 21), 1'b1, 4'(i - 1));
    end
    step();
    check_eq("t4_done", 32'(DONE), 32'd1);
    check_eq("t4_trig_addr", 32'(TRIG_ADDR), 32'd4);
    check_eq("t4_last_addr", 32'(sram.SRAM_ADDR), 32'd6);

    // 5: overflow write needs RLE_EN; nothing moves with CLK_EN low
    wr_base = wr_count;
    start_cap(8'd0, 8'd5);
    RLE_EN = 1'b1; LA_DATA = 8'hA5; LA_RLE_CNT = 8'hFF;
    exp_q.push_back({4'd0, 8'hA5, 8'hFF});
    step();
    RLE_EN = 1'b0;
    step();
    CLK_EN = 1'b0; LA_SRAM_ADDR_CNT_EN = 1'b1;
    step();
    CLK_EN = 1'b1; LA_SRAM_ADDR_CNT_EN = 1'b0; LA_RLE_CNT = 8'h00;
    check_eq("t5_writes", 32'(wr_count - wr_base), 32'd1);
    check_eq("t5_busy", 32'(BUSY), 32'd1);
    check_eq("t5_no_trig", 32'(TRIGGERED), 32'd0);

    // 6: ABORT in POST suppresses the write; ABORT beats START
    wr_base = wr_count;
    rec(8'h61, 1'b1, 1'b1, 4'd1);
    check_eq("t6_trig", 32'(TRIGGERED), 32'd1);
    rec(8'h62, 1'b0, 1'b1, 4'd2);
    ABORT = 1'b1;
    rec(8'h63, 1'b0, 1'b0, 4'd3);
    ABORT = 1'b0;
    check_eq("t6_we_high", 32'(sram.SRAM_WE_N), 32'd1);
    check_eq("t6_abort_flags", {29'b0, BUSY, TRIGGERED, DONE}, 32'd2);
    check_eq("t6_trig_addr", 32'(TRIG_ADDR), 32'd1);
    START = 1'b1; ABORT = 1'b1;
    step();
    START = 1'b0; ABORT = 1'b0;
    check_eq("t6_start_abort", 32'(BUSY), 32'd0);
    rec(8'h64, 1'b0, 1'b0, 4'd0);
    step();
    check_eq("t6_idle_busy", 32'(BUSY), 32'd0);
    check_eq("t6_writes", 32'(wr_count - wr_base), 32'd2);
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
